// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // One bundle of pipeline-register controls, MSB first.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
    } ctrl_t;

    // Normal advance: every register loads, nothing squashed.
    localparam ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                   idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};
    // Held in reset: front end frozen, every downstream stage squashed.
    localparam ctrl_t CTRL_RST = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                   idex_bubble: 1'b1, exmem_write: 1'b0, memwb_bubble: 1'b1};
    // Data-memory wait: whole pipe holds, MEM_WB receives a bubble.
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};
    // Load-use: hold PC and IF_ID, inject a bubble into ID_EX.
    localparam ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                     idex_bubble: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};
    // Taken branch/jump: squash the wrong-path fetch.
    localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                     idex_bubble: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection between the load in EX and the instruction in ID.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       ex_memread_i,
    input  logic [4:0] ex_rtaddr_i,
    input  logic [4:0] id_rsaddr_i,
    input  logic [4:0] id_rtaddr_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o
);

    logic rs_match;
    logic rt_match;

    // A load targeting r0 never creates a dependency.
    always_comb begin
        rs_match   = (ex_rtaddr_i == id_rsaddr_i);
        rt_match   = id_uses_rt_i && (ex_rtaddr_i == id_rtaddr_i);
        load_use_o = ex_memread_i && (ex_rtaddr_i != REG_ZERO) && (rs_match || rt_match);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, data-memory wait freezes with timeout, and saturating statistics.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned TO_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rsaddr_i,
    input  logic [4:0]       id_rtaddr_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rtaddr_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic             timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] wait_cnt_q;
    logic            load_use;
    logic            mem_wait;
    logic            wait_hit;
    logic            frozen;
    ctrl_t           ctrl;

    hazard_detect u_hazard_detect (
        .ex_memread_i (ex_memread_i),
        .ex_rtaddr_i  (ex_rtaddr_i),
        .id_rsaddr_i  (id_rsaddr_i),
        .id_rtaddr_i  (id_rtaddr_i),
        .id_uses_rt_i (id_uses_rt_i),
        .load_use_o   (load_use)
    );

    // Freeze/timeout qualifiers shared by next-state and output logic.
    // The entry cycle in RUN counts as the first frozen cycle, so after
    // TIMEOUT frozen cycles the next MEM_WAIT cycle is released.
    always_comb begin
        mem_wait = dmem_req_i && !dmem_ready_i;
        wait_hit = (state_q == MEM_WAIT) && !dmem_ready_i && (wait_cnt_q == TO_W'(TIMEOUT));
        frozen   = ((state_q == RUN) && mem_wait) ||
                   ((state_q == MEM_WAIT) && !dmem_ready_i && !wait_hit);
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RUN;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:      if (mem_wait) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem_ready_i || wait_hit) state_d = RUN;
            default:  state_d = RUN;
        endcase
    end

    // Output mux: reset > memory freeze > load-use > branch flush > run.
    always_comb begin
        ctrl = CTRL_RUN;
        if (rst_i)               ctrl = CTRL_RST;
        else if (frozen)         ctrl = CTRL_FREEZE;
        else if (load_use)       ctrl = CTRL_STALL;
        else if (branch_taken_i) ctrl = CTRL_FLUSH;
    end

    assign pc_write_o     = ctrl.pc_write;
    assign ifid_write_o   = ctrl.ifid_write;
    assign ifid_flush_o   = ctrl.ifid_flush;
    assign idex_bubble_o  = ctrl.idex_bubble;
    assign exmem_write_o  = ctrl.exmem_write;
    assign memwb_bubble_o = ctrl.memwb_bubble;

    // Wait counter tracks frozen cycles of the current memory access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wait_cnt_q <= '0;
        end else if (state_q == RUN) begin
            wait_cnt_q <= mem_wait ? TO_W'(1) : '0;
        end else if (dmem_ready_i || wait_hit) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + TO_W'(1);
        end
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)         timeout_o <= 1'b0;
        else if (wait_hit) timeout_o <= 1'b1;
    end

    // Saturating stall and flush statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (!ctrl.pc_write && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (ctrl.ifid_flush && (flush_cnt_o != '1)) flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule
